// File: rtl/id_decoder.sv
// RV32I-subset decode stage: registers decoded fields into ID/EX, inserts load-use
// bubbles, honours downstream stall and branch flush, and counts illegal instructions.
module id_decoder #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CNT_W  = 8
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_valid,
    input  logic [DATA_W-1:0] i_instr,
    input  logic [DATA_W-1:0] i_pc,
    input  logic              i_stall,
    input  logic              i_flush,
    output logic              o_ready,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_pc,
    output logic [4:0]        o_rd,
    output logic [4:0]        o_rs1,
    output logic [4:0]        o_rs2,
    output logic [DATA_W-1:0] o_imm,
    output logic [1:0]        o_alu_op,
    output logic              o_alu_src_imm,
    output logic              o_reg_we,
    output logic              o_mem_re,
    output logic              o_mem_we,
    output logic              o_branch,
    output logic              o_illegal,
    output logic [CNT_W-1:0]  o_illegal_cnt
);

    localparam logic [1:0] AluAdd  = 2'd0;
    localparam logic [1:0] AluSub  = 2'd1;
    localparam logic [1:0] AluSll  = 2'd2;
    localparam logic [1:0] AluPass = 2'd3;

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rd, rs1, rs2;

    logic        legal;
    logic [1:0]  alu_op_d;
    logic        src_imm_d, reg_we_raw, mem_re_d, mem_we_d, branch_d;
    logic        use_rs1, use_rs2;
    logic [31:0] imm32;
    logic [DATA_W-1:0] imm_d;

    logic        hazard, take, hold;

    assign opcode = i_instr[6:0];
    assign funct3 = i_instr[14:12];
    assign funct7 = i_instr[31:25];
    assign rd     = i_instr[11:7];
    assign rs1    = i_instr[19:15];
    assign rs2    = i_instr[24:20];

    always_comb begin
        legal      = 1'b0;
        alu_op_d   = AluAdd;
        src_imm_d  = 1'b0;
        reg_we_raw = 1'b0;
        mem_re_d   = 1'b0;
        mem_we_d   = 1'b0;
        branch_d   = 1'b0;
        use_rs1    = 1'b0;
        use_rs2    = 1'b0;
        imm32      = 32'h0;
        case (opcode)
            7'b0110111: begin
                legal      = 1'b1;
                alu_op_d   = AluPass;
                src_imm_d  = 1'b1;
                reg_we_raw = 1'b1;
                imm32      = {i_instr[31:12], 12'h000};
            end
            7'b0110011: begin
                if (funct3 == 3'b000 && funct7 == 7'b0000000) begin
                    legal    = 1'b1;
                    alu_op_d = AluAdd;
                end else if (funct3 == 3'b000 && funct7 == 7'b0100000) begin
                    legal    = 1'b1;
                    alu_op_d = AluSub;
                end else if (funct3 == 3'b001 && funct7 == 7'b0000000) begin
                    legal    = 1'b1;
                    alu_op_d = AluSll;
                end
                reg_we_raw = legal;
                use_rs1    = legal;
                use_rs2    = legal;
            end
            7'b0010011: begin
                if (funct3 == 3'b000) begin
                    legal      = 1'b1;
                    src_imm_d  = 1'b1;
                    reg_we_raw = 1'b1;
                    use_rs1    = 1'b1;
                    imm32      = {{20{i_instr[31]}}, i_instr[31:20]};
                end
            end
            7'b1100011: begin
                if (funct3 == 3'b000) begin
                    legal    = 1'b1;
                    alu_op_d = AluSub;
                    branch_d = 1'b1;
                    use_rs1  = 1'b1;
                    use_rs2  = 1'b1;
                    imm32    = {{19{i_instr[31]}}, i_instr[31], i_instr[7],
                                i_instr[30:25], i_instr[11:8], 1'b0};
                end
            end
            7'b0100011: begin
                if (funct3 == 3'b010) begin
                    legal     = 1'b1;
                    src_imm_d = 1'b1;
                    mem_we_d  = 1'b1;
                    use_rs1   = 1'b1;
                    use_rs2   = 1'b1;
                    imm32     = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
                end
            end
            7'b0000011: begin
                if (funct3 == 3'b010) begin
                    legal      = 1'b1;
                    src_imm_d  = 1'b1;
                    reg_we_raw = 1'b1;
                    mem_re_d   = 1'b1;
                    use_rs1    = 1'b1;
                    imm32      = {{20{i_instr[31]}}, i_instr[31:20]};
                end
            end
            default: ;
        endcase
    end

    assign imm_d = DATA_W'($signed(imm32));

    // o_mem_re is only ever set for a valid LW sitting in ID/EX
    assign hazard = o_valid & o_mem_re & (o_rd != 5'd0) & i_valid &
                    ((use_rs1 & (rs1 == o_rd)) | (use_rs2 & (rs2 == o_rd)));

    assign o_ready = ~i_rst & (i_flush | (~i_stall & ~hazard));
    assign take    = ~i_rst & ~i_flush & ~i_stall & ~hazard & i_valid;
    assign hold    = ~i_rst & ~i_flush & i_stall;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_illegal_cnt <= '0;
        end else if (take && !legal && o_illegal_cnt != {CNT_W{1'b1}}) begin
            o_illegal_cnt <= o_illegal_cnt + 1'b1;
        end

        // Reset, flush, hazard and idle cycles all load a bubble (take = 0)
        if (!hold) begin
            o_valid       <= take;
            o_pc          <= take ? i_pc  : '0;
            o_rd          <= take ? rd    : 5'd0;
            o_rs1         <= take ? rs1   : 5'd0;
            o_rs2         <= take ? rs2   : 5'd0;
            o_imm         <= take ? imm_d : '0;
            o_alu_op      <= take ? alu_op_d : AluAdd;
            o_alu_src_imm <= take & src_imm_d;
            o_reg_we      <= take & reg_we_raw & (rd != 5'd0);
            o_mem_re      <= take & mem_re_d;
            o_mem_we      <= take & mem_we_d;
            o_branch      <= take & branch_d;
            o_illegal     <= take & ~legal;
        end
    end

endmodule

// File: tb/tb_id_decoder.sv
// Scoreboard bench for id_decoder: a mnemonic-level reference model predicts o_ready and the
// ID/EX contents each cycle; a monitor compares the registered outputs after every edge.
module tb_id_decoder;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, valid, stall, flush;
    logic [31:0] instr, pc;
    logic        ready, o_valid, src_imm, reg_we, mem_re, mem_we, branch, illegal;
    logic [31:0] o_pc, imm;
    logic [4:0]  rd, rs1, rs2;
    logic [1:0]  alu_op;
    logic [7:0]  cnt;

    id_decoder #(.DATA_W(32), .CNT_W(8)) dut (
        .i_clk(clk), .i_rst(rst), .i_valid(valid), .i_instr(instr), .i_pc(pc),
        .i_stall(stall), .i_flush(flush), .o_ready(ready), .o_valid(o_valid), .o_pc(o_pc),
        .o_rd(rd), .o_rs1(rs1), .o_rs2(rs2), .o_imm(imm), .o_alu_op(alu_op),
        .o_alu_src_imm(src_imm), .o_reg_we(reg_we), .o_mem_re(mem_re), .o_mem_we(mem_we),
        .o_branch(branch), .o_illegal(illegal), .o_illegal_cnt(cnt)
    );

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [4:0]  rd, rs1, rs2;
        logic [31:0] imm;
        logic [1:0]  alu_op;
        logic        src_imm, reg_we, mem_re, mem_we, branch, illegal;
        logic [7:0]  cnt;
    } out_t;

    typedef enum {MLui, MAdd, MSub, MSll, MAddi, MBeq, MSw, MLw, MIll} mnem_t;

    int   n_tests = 0;
    int   n_fail  = 0;
    out_t q[$];
    out_t st;
    int   pc_ctr = 32'h1000;

    function automatic mnem_t classify(input logic [31:0] w);
        if (w[6:0] == 7'h37)                      return MLui;
        if ((w & 32'hFE00707F) == 32'h00000033)   return MAdd;
        if ((w & 32'hFE00707F) == 32'h40000033)   return MSub;
        if ((w & 32'hFE00707F) == 32'h00001033)   return MSll;
        if ((w & 32'h0000707F) == 32'h00000013)   return MAddi;
        if ((w & 32'h0000707F) == 32'h00000063)   return MBeq;
        if ((w & 32'h0000707F) == 32'h00002023)   return MSw;
        if ((w & 32'h0000707F) == 32'h00002003)   return MLw;
        return MIll;
    endfunction

    // {reads rs1, reads rs2}
    function automatic logic [1:0] reads(input mnem_t m);
        case (m)
            MAdd, MSub, MSll, MBeq, MSw: return 2'b11;
            MAddi, MLw:                  return 2'b10;
            default:                     return 2'b00;
        endcase
    endfunction

    function automatic out_t ref_decode(input logic [31:0] w, input logic [31:0] p);
        out_t  o;
        mnem_t m;
        int    s;
        m = classify(w);
        s = w[31] ? -1 : 0;
        o = '0;
        o.valid = 1'b1;
        o.pc    = p;
        o.rd    = w[11:7];
        o.rs1   = w[19:15];
        o.rs2   = w[24:20];
        case (m)
            MLui:  begin o.alu_op = 2'd3; o.src_imm = 1'b1; o.imm = w & 32'hFFFFF000; end
            MAdd:  o.alu_op = 2'd0;
            MSub:  o.alu_op = 2'd1;
            MSll:  o.alu_op = 2'd2;
            MAddi: begin o.src_imm = 1'b1; o.imm = 32'(s * 2048 + int'(w[30:20])); end
            MLw:   begin
                o.src_imm = 1'b1; o.mem_re = 1'b1; o.imm = 32'(s * 2048 + int'(w[30:20]));
            end
            MSw:   begin
                o.src_imm = 1'b1; o.mem_we = 1'b1;
                o.imm = 32'(s * 2048 + int'(w[30:25]) * 32 + int'(w[11:7]));
            end
            MBeq:  begin
                o.alu_op = 2'd1; o.branch = 1'b1;
                o.imm = 32'(s * 4096 + int'(w[7]) * 2048 + int'(w[30:25]) * 32 +
                            int'(w[11:8]) * 2);
            end
            default: o.illegal = 1'b1;
        endcase
        o.reg_we = (m inside {MLui, MAdd, MSub, MSll, MAddi, MLw}) && (o.rd != 5'd0);
        return o;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Drive one cycle of inputs, check o_ready, and queue the predicted ID/EX state.
    task automatic step(input logic r, input logic v, input logic [31:0] w,
                        input logic s, input logic f);
        out_t        nxt;
        logic        hz, exp_ready;
        logic [1:0]  use_m;
        @(negedge clk);
        rst = r; valid = v; instr = w; pc = pc_ctr; stall = s; flush = f;
        #1;
        use_m = reads(classify(w));
        hz = st.valid && st.mem_re && st.rd != 5'd0 && v &&
             ((use_m[1] && w[19:15] == st.rd) || (use_m[0] && w[24:20] == st.rd));
        exp_ready = !r && (f || (!s && !hz));
        n_tests++;
        if (ready !== exp_ready) begin
            n_fail++;
            $display("FAIL ready @%0t: got %b expected %b", $time, ready, exp_ready);
        end
        if (r) begin
            nxt = '0;
        end else if (f) begin
            nxt = '0; nxt.cnt = st.cnt;
        end else if (s) begin
            nxt = st;
        end else if (hz || !v) begin
            nxt = '0; nxt.cnt = st.cnt;
        end else begin
            nxt = ref_decode(w, pc_ctr);
            nxt.cnt = (nxt.illegal && st.cnt < 8'd255) ? st.cnt + 8'd1 : st.cnt;
        end
        if (exp_ready && v) pc_ctr += 4;
        q.push_back(nxt);
        st = nxt;
    endtask

    task automatic after_edge();
        @(posedge clk);
        #2;
    endtask

    always @(posedge clk) begin
        out_t e, a;
        #1;
        if (q.size() > 0) begin
            e = q.pop_front();
            a = {o_valid, o_pc, rd, rs1, rs2, imm, alu_op, src_imm, reg_we, mem_re, mem_we,
                 branch, illegal, cnt};
            n_tests++;
            if (a !== e) begin
                n_fail++;
                $display("FAIL outputs @%0t: got %h expected %h", $time, a, e);
            end
        end
    end

    function automatic logic [31:0] rand_instr();
        logic [4:0]  regs [5] = '{5'd0, 5'd1, 5'd2, 5'd10, 5'd11};
        logic [4:0]  d, a, b;
        logic [31:0] r;
        r = $urandom;
        d = regs[$urandom_range(0, 4)];
        a = regs[$urandom_range(0, 4)];
        b = regs[$urandom_range(0, 4)];
        case ($urandom_range(0, 10))
            0:  return {r[31:12], d, 7'h37};
            1:  return {7'h00, b, a, 3'b000, d, 7'h33};
            2:  return {7'h20, b, a, 3'b000, d, 7'h33};
            3:  return {7'h00, b, a, 3'b001, d, 7'h33};
            4:  return {r[31:20], a, 3'b000, d, 7'h13};
            5:  return {r[31:25], b, a, 3'b000, r[11:7], 7'h63};
            6:  return {r[31:25], b, a, 3'b010, r[11:7], 7'h23};
            7, 8: return {r[31:20], a, 3'b010, d, 7'h03};
            9:  return {7'h01, b, a, 3'b000, d, 7'h33};
            default: return r;
        endcase
    endfunction

    initial begin
        rst = 1'b1; valid = 1'b0; instr = '0; pc = '0; stall = 1'b0; flush = 1'b0;
        st = '0;
        step(1, 0, 32'h0, 0, 0);
        step(1, 1, 32'h00108093, 0, 0);
        after_edge();
        chk("reset_cnt", {24'h0, cnt}, 32'h0);
        chk("reset_valid", {31'h0, o_valid}, 32'h0);

        step(0, 1, 32'h00108093, 0, 0);
        after_edge();
        chk("addi_imm", imm, 32'h1);
        chk("addi_ctl", {26'h0, alu_op, src_imm, reg_we, rd[1:0]}, 32'h0000000D);

        step(0, 1, 32'h00ABF437, 0, 0);
        after_edge();
        chk("lui_imm", imm, 32'h00ABF000);
        chk("lui_rd_op", {25'h0, rd, alu_op}, {25'h0, 5'd8, 2'd3});

        step(0, 1, 32'hFE0086E3, 0, 0);
        after_edge();
        chk("beq_imm", imm, 32'hFFFFFFEC);
        chk("beq_ctl", {29'h0, branch, reg_we, rs1[0]}, 32'h5);

        step(0, 1, 32'h00402503, 0, 0);
        step(0, 1, 32'h009505B3, 0, 0);
        step(0, 1, 32'h009505B3, 0, 0);
        after_edge();
        chk("lu_add_regs", {17'h0, rd, rs1, rs2}, {17'h0, 5'd11, 5'd10, 5'd9});
        step(0, 1, 32'h00402503, 0, 0);
        step(0, 1, 32'h00902223, 0, 0);

        step(0, 1, 32'h00108093, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 1, 32'h009505B3, 1, 0);
        step(0, 1, 32'h009505B3, 0, 0);

        step(0, 1, 32'h00000000, 1, 1);
        after_edge();
        chk("flush_cnt", {24'h0, cnt}, 32'h0);

        step(0, 1, 32'h00000000, 0, 0);
        after_edge();
        chk("ill_zero", {24'h0, cnt}, 32'h1);
        chk("ill_en", {26'h0, illegal, reg_we, mem_re, mem_we, branch, src_imm}, 32'h20);
        for (int i = 0; i < 300; i++) step(0, 1, $urandom | 32'h7F, 0, 0);
        after_edge();
        chk("ill_sat", {24'h0, cnt}, 32'hFF);
        step(0, 1, 32'h00000033, 0, 0);
        after_edge();
        chk("add_x0", {30'h0, illegal, reg_we}, 32'h0);
        step(1, 0, 32'h0, 0, 0);
        after_edge();
        chk("rst_cnt", {24'h0, cnt}, 32'h0);

        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 199) == 0), ($urandom_range(0, 3) != 0), rand_instr(),
                 ($urandom_range(0, 5) == 0), ($urandom_range(0, 15) == 0));
        end
        step(0, 0, 32'h0, 0, 0);
        repeat (3) @(posedge clk);
        #2;
        n_tests++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/id_decoder.md
# id_decoder

Decode stage for the core's RV32I subset (LUI, ADD, SUB, ADDI, SLL, BEQ, SW, LW). It sits between instruction fetch and execute, and consumes the 32-bit word and PC delivered by fetch. It produces registered control fields, register addresses and a sign-extended immediate into the ID/EX pipeline register. It also detects load-use hazards and inserts bubbles, and it honours downstream stall and branch flush.

## Interface
- DATA_W, 32, instruction, PC and immediate width
- CNT_W, 8, illegal-instruction counter width
- i_clk  in  1  rising-edge clock
- i_rst  in  1  synchronous reset, active-high
- i_valid  in  1  fetch presents a valid instruction
- i_instr  in  DATA_W  instruction word
- i_pc  in  DATA_W  PC of i_instr
- i_stall  in  1  execute cannot accept; hold ID/EX register
- i_flush  in  1  taken branch; squash ID/EX and the presented instruction
- o_ready  out  1  combinational; instruction accepted this cycle when i_valid & o_ready
- o_valid, o_pc, o_rd, o_rs1, o_rs2 (5b), o_imm (DATA_W)  out  registered decoded fields
- o_alu_op  out  2  0 ADD, 1 SUB, 2 SLL, 3 PASS_IMM
- o_alu_src_imm, o_reg_we, o_mem_re, o_mem_we, o_branch, o_illegal  out  1 each
- o_illegal_cnt  out  CNT_W  saturating count of accepted illegal instructions

## Operation
- **Decode keys:** opcode[6:0], funct3[14:12], funct7[31:25].
  - 0110111 LUI
  - 0110011 with funct3/funct7 000/0000000 ADD, 000/0100000 SUB, 001/0000000 SLL
  - 0010011 with funct3 000: ADDI
  - 1100011 with funct3 000: BEQ
  - 0100011 with funct3 010: SW
  - 0000011 with funct3 010: LW
  - Anything else is illegal, including 0x00000000.
- **Immediates:**
  - I: sext(instr[31:20])
  - S: sext({[31:25],[11:7]})
  - B: sext({[31],[7],[30:25],[11:8],0})
  - U: {[31:12],12'b0}
  - R and illegal: 0
- **Controls:**
  - ALU ops: ADD/SUB/SLL select their own o_alu_op; ADDI, LW and SW use ADD with src_imm=1.
  - LUI uses PASS_IMM with src_imm=1.
  - BEQ uses SUB with o_branch=1.
  - LW sets mem_re; SW sets mem_we.
  - o_reg_we=1 for LUI/ADD/SUB/SLL/ADDI/LW, forced to 0 when rd=0.
- **Illegal instructions:** o_valid=1, o_illegal=1, all enables 0, rd/rs fields still extracted.
- **Register-use mask:** ADD/SUB/SLL/BEQ/SW read rs1 and rs2; ADDI/LW read rs1; LUI and illegal read none.
- **Load-use hazard:** ID/EX holds a valid LW with rd≠0, and the presented valid instruction reads that rd per the use-mask.
- **Per-cycle priority:** reset > flush > stall > hazard > normal.
  - **Flush:** next state o_valid=0, all fields 0; o_ready=1, so the presented instruction is consumed and discarded; not counted even if illegal.
  - **Stall:** ID/EX holds all values; o_ready=0.
  - **Hazard:** load a bubble (o_valid=0, fields 0); o_ready=0; the same instruction is accepted the following cycle.
  - **Normal:** o_ready=1. If i_valid, load the decoded instruction; otherwise load a bubble.
- **Counter:** increments on acceptance of an illegal instruction in a normal cycle; saturates at 2^CNT_W−1; cleared only by reset.

## Timing
- **Reset:** while i_rst=1, o_ready=0. At the edge, every registered output, including o_illegal_cnt, becomes 0.
- **Latency:** one cycle. An instruction accepted at edge N appears on the outputs after edge N.
- **Throughput:** one instruction per cycle with no hazard or stall.
- **Load-use bubble:** exactly one cycle per load-use pair. If i_stall holds the LW in ID/EX, the hazard persists until the LW leaves.
- **Flush with stall:** flush wins; ID/EX clears even though i_stall=1.
- **Reset mid-hazard or mid-stall:** everything clears; no pending instruction is retained (fetch re-presents).
- **o_ready:** purely combinational from i_rst, i_flush, i_stall, ID/EX state and i_instr; no path from o_ready back to itself.

## Test plan
- **Basic decode:** 0x00108093 → next cycle o_valid=1, rd=1, rs1=1, imm=1, alu_op=ADD, src_imm=1, reg_we=1.
- **U and B immediates:**
  - 0x00ABF437 → rd=8, imm=0x00ABF000, alu_op=PASS_IMM.
  - 0xFE0086E3 → o_branch=1, rs1=1, rs2=0, imm=0xFFFFFFEC, reg_we=0.
- **Load-use:** 0x00402503 (LW x10,4(x0)) then 0x009505B3 (ADD x11,x10,x9).
  - Cycle 2: o_ready=0, bubble loaded.
  - Cycle 3: ADD accepted; outputs rd=11, rs1=10, rs2=9.
  - Repeat with 0x00902223 (SW, no x10 read) after the LW → no bubble.
- **Stall:** hold i_stall=1 for 3 cycles with ADD presented → outputs frozen, o_ready=0; ADD accepted on the first cycle after release.
- **Flush:** assert i_flush together with i_stall while ID/EX is valid → o_valid=0 next cycle, presented instruction dropped, counter unchanged.
- **Illegal and saturation:**
  - Present 0x00000000 → o_illegal=1, all enables 0, count=1.
  - Continue presenting illegal instructions → count saturates at 255.
  - 0x00000033 (ADD x0,x0,x0) → legal, reg_we=0.
  - Pulse i_rst → count=0.
